// File: rtl/data_memory_arbiter_if.sv
// Requester / memory bundle for data_memory_arbiter. The statistics outputs exist
// only when ARB_STATS_EN is defined.
interface data_memory_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             Arbiter_REQ0, Arbiter_REQ1;
  logic             Arbiter_WE0, Arbiter_WE1;
  logic [WIDTH-1:0] Arbiter_A0, Arbiter_A1;
  logic [WIDTH-1:0] Arbiter_WD0, Arbiter_WD1;
  logic             Arbiter_GNT0, Arbiter_GNT1;
  logic [WIDTH-1:0] Arbiter_RD0, Arbiter_RD1;
  logic             Arbiter_RVALID0, Arbiter_RVALID1;
  logic [WIDTH-1:0] Mem_A;
  logic [WIDTH-1:0] Mem_WD;
  logic             Mem_WE;
  logic [WIDTH-1:0] Mem_RD;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] Arbiter_GCNT0, Arbiter_GCNT1, Arbiter_CONFLICT;
`endif

  // Arbiter side
  modport slave (
    input  Arbiter_REQ0, Arbiter_REQ1, Arbiter_WE0, Arbiter_WE1,
    input  Arbiter_A0, Arbiter_A1, Arbiter_WD0, Arbiter_WD1,
    output Arbiter_GNT0, Arbiter_GNT1, Arbiter_RD0, Arbiter_RD1,
    output Arbiter_RVALID0, Arbiter_RVALID1,
    output Mem_A, Mem_WD, Mem_WE,
    input  Mem_RD
`ifdef ARB_STATS_EN
    , output Arbiter_GCNT0, Arbiter_GCNT1, Arbiter_CONFLICT
`endif
  );

  // Requesters plus memory side
  modport master (
    output Arbiter_REQ0, Arbiter_REQ1, Arbiter_WE0, Arbiter_WE1,
    output Arbiter_A0, Arbiter_A1, Arbiter_WD0, Arbiter_WD1,
    input  Arbiter_GNT0, Arbiter_GNT1, Arbiter_RD0, Arbiter_RD1,
    input  Arbiter_RVALID0, Arbiter_RVALID1,
    input  Mem_A, Mem_WD, Mem_WE,
    output Mem_RD
`ifdef ARB_STATS_EN
    , input Arbiter_GCNT0, Arbiter_GCNT1, Arbiter_CONFLICT
`endif
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Burst-limited round-robin arbiter sharing one single-port data memory between the
// core (port 0) and the DMA/debug loader (port 1). Define ARB_STATS_EN for grant/conflict counters.
module data_memory_arbiter #(
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 Arbiter_CLK,
  input  logic                 Arbiter_RST,
  data_memory_arbiter_if.slave bus
);
  localparam int             BW   = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]  BMAX = BW'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q;
  logic [BW-1:0]    burst_q, burst_d;
  logic             last_q;            // 1 = port 1 owned last
  logic [WIDTH-1:0] rd0_q, rd1_q;
  logic             rvalid0_q, rvalid1_q;

  logic both, pick1, gnt0, gnt1, same_owner;

  always_comb begin
    both  = bus.Arbiter_REQ0 & bus.Arbiter_REQ1;
    pick1 = bus.Arbiter_REQ1;
    if (both) begin
      case (state_q)
        OWN0:    pick1 = (burst_q >= BMAX);
        OWN1:    pick1 = (burst_q < BMAX);
        default: pick1 = ~last_q;
      endcase
    end
    gnt0 = ~Arbiter_RST & bus.Arbiter_REQ0 & ~pick1;
    gnt1 = ~Arbiter_RST & bus.Arbiter_REQ1 & pick1;

    same_owner = ((state_q == OWN0) & gnt0) | ((state_q == OWN1) & gnt1);
    burst_d    = BW'(1);
    if (same_owner)
      burst_d = (burst_q == BMAX) ? BMAX : burst_q + BW'(1);
  end

  assign bus.Arbiter_GNT0    = gnt0;
  assign bus.Arbiter_GNT1    = gnt1;
  assign bus.Mem_A           = gnt1 ? bus.Arbiter_A1  : bus.Arbiter_A0;
  assign bus.Mem_WD          = gnt1 ? bus.Arbiter_WD1 : bus.Arbiter_WD0;
  assign bus.Mem_WE          = (gnt0 & bus.Arbiter_WE0) | (gnt1 & bus.Arbiter_WE1);
  assign bus.Arbiter_RD0     = rd0_q;
  assign bus.Arbiter_RD1     = rd1_q;
  assign bus.Arbiter_RVALID0 = rvalid0_q;
  assign bus.Arbiter_RVALID1 = rvalid1_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] gcnt0_q, gcnt1_q, conflict_q;
  assign bus.Arbiter_GCNT0    = gcnt0_q;
  assign bus.Arbiter_GCNT1    = gcnt1_q;
  assign bus.Arbiter_CONFLICT = conflict_q;
`endif

  always_ff @(posedge Arbiter_CLK or posedge Arbiter_RST) begin
    if (Arbiter_RST) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      last_q    <= 1'b1;
      rd0_q     <= '0;
      rd1_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef ARB_STATS_EN
      gcnt0_q    <= '0;
      gcnt1_q    <= '0;
      conflict_q <= '0;
`endif
    end else begin
      rvalid0_q <= gnt0 & ~bus.Arbiter_WE0;
      rvalid1_q <= gnt1 & ~bus.Arbiter_WE1;
      if (gnt0 & ~bus.Arbiter_WE0) rd0_q <= bus.Mem_RD;
      if (gnt1 & ~bus.Arbiter_WE1) rd1_q <= bus.Mem_RD;

      if (gnt0 | gnt1) begin
        state_q <= gnt1 ? OWN1 : OWN0;
        last_q  <= gnt1;
        burst_q <= burst_d;
      end else begin
        state_q <= IDLE;
        burst_q <= '0;
      end
`ifdef ARB_STATS_EN
      gcnt0_q    <= gcnt0_q + CNT_W'(gnt0);
      gcnt1_q    <= gcnt1_q + CNT_W'(gnt1);
      conflict_q <= conflict_q + CNT_W'(both);
`endif
    end
  end
endmodule
